// File: rtl/pixie_scandoubler.sv
// rtl/pixie_scandoubler.sv - CDP1861 line doubler: two-bank line store replayed twice per input line.
// Optional PIXIE_SCANLINE_EN: second pass of each line is dimmed to half intensity.
module pixie_scandoubler #(
    parameter int          LINE_PIXELS = 112,
    parameter int          HSYNC_WIDTH = 8,
    parameter logic [23:0] FG_RGB      = 24'hFFFFFF,
    parameter logic [23:0] BG_RGB      = 24'h000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce_pix_in,
    input  logic       ce_pix_out,
    input  logic       video_in,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       hblank_in,
    input  logic       vblank_in,
    output logic [7:0] r,
    output logic [7:0] g,
    output logic [7:0] b,
    output logic       hs_out,
    output logic       vs_out,
    output logic       hblank_out,
    output logic       vblank_out,
    output logic       de_out,
    output logic       overflow
);

    localparam int PW = $clog2(LINE_PIXELS + 1);
    localparam logic [PW-1:0] MAX_PTR = PW'(LINE_PIXELS);
    localparam logic [PW-1:0] HS_LEN  = PW'(HSYNC_WIDTH);

    typedef enum logic [1:0] {IDLE, PASS0, PASS1, WAIT} state_t;

    logic [1:0]    line_buf [2][LINE_PIXELS];
    logic          hsync_q;
    logic          hs_edge;
    logic          wr_bank;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] len;
    logic          vs_lat;
    logic          vb_lat;
    logic          synced;

    state_t        state, state_n;
    logic          rd_bank, rd_bank_n;
    logic [PW-1:0] rd_ptr, rd_ptr_n;
    logic [PW-1:0] last_ptr;

    logic [1:0]    rd_data;
    logic          s1_active;
    logic          s1_hs;
    logic          s1_vs;
    logic          s1_vb;
    logic          ce_q;
`ifdef PIXIE_SCANLINE_EN
    logic          s1_pass1;
`endif

    logic          hb_n;
    logic          de_n;
    logic [23:0]   rgb_n;

    assign hs_edge  = ce_pix_in & hsync_in & ~hsync_q;
    assign last_ptr = len - 1'b1;

    // Line store: plain RAM, no reset; the pixel on the hsync edge tick is not stored
    always_ff @(posedge clk) begin
        if (ce_pix_in && !hs_edge && (wr_ptr < MAX_PTR))
            line_buf[wr_bank][wr_ptr] <= {video_in, hblank_in};
        if (ce_pix_out)
            rd_data <= line_buf[rd_bank][rd_ptr];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hsync_q  <= 1'b0;
            wr_bank  <= 1'b0;
            wr_ptr   <= '0;
            len      <= '0;
            vs_lat   <= 1'b0;
            vb_lat   <= 1'b0;
            synced   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (ce_pix_in)
                hsync_q <= hsync_in;
            if (hs_edge) begin
                len     <= wr_ptr;
                wr_ptr  <= '0;
                wr_bank <= ~wr_bank;
                vs_lat  <= vsync_in;
                vb_lat  <= vblank_in;
                synced  <= 1'b1;
            end else if (ce_pix_in) begin
                if (wr_ptr < MAX_PTR)
                    wr_ptr <= wr_ptr + 1'b1;
                else
                    overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            rd_bank <= 1'b0;
            rd_ptr  <= '0;
        end else begin
            state   <= state_n;
            rd_bank <= rd_bank_n;
            rd_ptr  <= rd_ptr_n;
        end
    end

    // The line captured between reset release and the first edge is partial, so it is never replayed
    always_comb begin
        state_n   = state;
        rd_bank_n = rd_bank;
        rd_ptr_n  = rd_ptr;
        if (hs_edge) begin
            rd_bank_n = wr_bank;
            rd_ptr_n  = '0;
            state_n   = (synced && (wr_ptr != '0)) ? PASS0 : WAIT;
        end else if (ce_pix_out) begin
            case (state)
                PASS0: begin
                    if (rd_ptr == last_ptr) begin
                        rd_ptr_n = '0;
                        state_n  = PASS1;
                    end else begin
                        rd_ptr_n = rd_ptr + 1'b1;
                    end
                end
                PASS1: begin
                    if (rd_ptr == last_ptr) begin
                        rd_ptr_n = '0;
                        state_n  = WAIT;
                    end else begin
                        rd_ptr_n = rd_ptr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Sideband travels alongside the registered RAM read so it lines up with rd_data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_active <= 1'b0;
            s1_hs     <= 1'b0;
            s1_vs     <= 1'b0;
            s1_vb     <= 1'b0;
            ce_q      <= 1'b0;
`ifdef PIXIE_SCANLINE_EN
            s1_pass1  <= 1'b0;
`endif
        end else begin
            ce_q <= ce_pix_out;
            if (ce_pix_out) begin
                s1_active <= (state == PASS0) || (state == PASS1);
                s1_hs     <= ((state == PASS0) || (state == PASS1)) && (rd_ptr < HS_LEN);
                s1_vs     <= vs_lat;
                s1_vb     <= vb_lat;
`ifdef PIXIE_SCANLINE_EN
                s1_pass1  <= (state == PASS1);
`endif
            end
        end
    end

    always_comb begin
        hb_n  = ~s1_active | rd_data[0];
        de_n  = ~(hb_n | s1_vb);
        rgb_n = 24'h0;
        if (de_n)
            rgb_n = rd_data[1] ? FG_RGB : BG_RGB;
`ifdef PIXIE_SCANLINE_EN
        if (s1_pass1)
            rgb_n = {1'b0, rgb_n[23:17], 1'b0, rgb_n[15:9], 1'b0, rgb_n[7:1]};
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r          <= 8'h0;
            g          <= 8'h0;
            b          <= 8'h0;
            hs_out     <= 1'b0;
            vs_out     <= 1'b0;
            hblank_out <= 1'b0;
            vblank_out <= 1'b0;
            de_out     <= 1'b0;
        end else if (ce_q) begin
            {r, g, b}  <= rgb_n;
            hs_out     <= s1_hs;
            vs_out     <= s1_vs;
            hblank_out <= hb_n;
            vblank_out <= s1_vb;
            de_out     <= de_n;
        end
    end

endmodule

// File: tb/tb_pixie_scandoubler.sv
// tb/tb_pixie_scandoubler.sv - directed bench for pixie_scandoubler: replay, overflow, truncation, vsync, reset.
module tb_pixie_scandoubler;

`ifdef PIXIE_SCANLINE_EN
    localparam bit SCAN = 1'b1;
`else
    localparam bit SCAN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ce_pix_in = 1'b0;
    logic       ce_pix_out = 1'b0;
    logic       video_in = 1'b0;
    logic       hsync_in = 1'b0;
    logic       vsync_in = 1'b0;
    logic       hblank_in = 1'b1;
    logic       vblank_in = 1'b0;
    logic [7:0] r, g, b;
    logic       hs_out, vs_out, hblank_out, vblank_out, de_out, overflow;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       hb;
        logic       vb;
        logic       de;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } samp_t;

    samp_t cap_q[$];
    samp_t de_q[$];
    logic  cap_en = 1'b0;
    logic  ce_d1 = 1'b0;
    logic  ce_d2 = 1'b0;
    int    vectors = 0;
    int    miscompares = 0;

    pixie_scandoubler dut (
        .clk(clk), .reset(reset), .ce_pix_in(ce_pix_in), .ce_pix_out(ce_pix_out),
        .video_in(video_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .hblank_in(hblank_in), .vblank_in(vblank_in),
        .r(r), .g(g), .b(b), .hs_out(hs_out), .vs_out(vs_out),
        .hblank_out(hblank_out), .vblank_out(vblank_out), .de_out(de_out), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Output regs load on the clk after each ce_pix_out tick; sample on the following negedge
    always @(posedge clk) begin
        ce_d1 <= ce_pix_out;
        ce_d2 <= ce_d1;
    end

    always @(negedge clk)
        if (cap_en && ce_d2)
            cap_q.push_back({hs_out, vs_out, hblank_out, vblank_out, de_out, r, g, b});

    function automatic logic pat(input int kind, input int i);
        logic [7:0] a5;
        a5 = 8'hA5;
        case (kind)
            1: return a5[7 - (i % 8)];
            2: return 1'b1;
            3: return (i < 112) && (i % 3 == 0);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [7:0] exp_col(input logic p, input logic pass1);
        if (!p) return 8'h00;
        if (pass1 && SCAN) return 8'h7F;
        return 8'hFF;
    endfunction

    task automatic pix(input logic v, input logic hs, input logic vs, input logic hb, input logic vb);
        for (int p = 0; p < 4; p++) begin
            @(negedge clk);
            video_in   = v;
            hsync_in   = hs;
            vsync_in   = vs;
            hblank_in  = hb;
            vblank_in  = vb;
            ce_pix_in  = (p == 0);
            ce_pix_out = (p % 2 == 0);
        end
    endtask

    // kind 0 is a blank line (hblank_in=1); others carry visible pixels
    task automatic line(input int n, input int kind, input logic vs_edge);
        pix(1'b0, 1'b1, vs_edge, 1'b1, 1'b0);
        for (int i = 0; i < n; i++)
            pix(pat(kind, i), 1'b0, 1'b0, (kind == 0), 1'b0);
    endtask

    task automatic open_capture();
        cap_q = {};
        cap_en = 1'b1;
    endtask

    task automatic close_capture();
        pix(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        cap_en = 1'b0;
        pix(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic collect_de();
        de_q = {};
        foreach (cap_q[i])
            if (cap_q[i].de)
                de_q.push_back(cap_q[i]);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({r, g, b, hs_out, vs_out, hblank_out, vblank_out, de_out, overflow} !== 30'h0) begin
            miscompares++;
            $display("FAIL reset_state: got %h expected 0",
                     {r, g, b, hs_out, vs_out, hblank_out, vblank_out, de_out, overflow});
        end
        reset = 1'b1;
        line(112, 0, 1'b0);
        line(112, 0, 1'b0);
    endtask

    task automatic test_pattern();
        logic [7:0] e;
        int         idx;
        int         hs_cnt;
        line(112, 1, 1'b0);
        open_capture();
        line(112, 0, 1'b0);
        close_capture();
        collect_de();
        vectors++;
        if (de_q.size() !== 224) begin
            miscompares++;
            $display("FAIL pattern_de_count: got %0d expected 224", de_q.size());
        end
        hs_cnt = 0;
        for (int i = 0; i < de_q.size() && i < 224; i++) begin
            idx = i % 112;
            e = exp_col(pat(1, idx), i >= 112);
            if (de_q[i].hs) hs_cnt++;
            vectors++;
            if ({de_q[i].r, de_q[i].g, de_q[i].b} !== {e, e, e} || de_q[i].hs !== (idx < 8)) begin
                miscompares++;
                $display("FAIL pattern_pixel[%0d]: got rgb=%h hs=%b expected rgb=%h hs=%b",
                         i, {de_q[i].r, de_q[i].g, de_q[i].b}, de_q[i].hs, {e, e, e}, (idx < 8));
            end
        end
        vectors++;
        if (hs_cnt !== 16) begin
            miscompares++;
            $display("FAIL pattern_hs_count: got %0d expected 16", hs_cnt);
        end
        vectors++;
        if (overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL pattern_no_overflow: got %b expected 0", overflow);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] e;
        line(120, 3, 1'b0);
        vectors++;
        if (overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow_flag: got %b expected 1", overflow);
        end
        open_capture();
        line(112, 0, 1'b0);
        close_capture();
        collect_de();
        vectors++;
        if (de_q.size() !== 224) begin
            miscompares++;
            $display("FAIL overflow_de_count: got %0d expected 224", de_q.size());
        end
        for (int i = 0; i < de_q.size() && i < 224; i++) begin
            e = exp_col(pat(3, i % 112), i >= 112);
            vectors++;
            if ({de_q[i].r, de_q[i].g, de_q[i].b} !== {e, e, e}) begin
                miscompares++;
                $display("FAIL overflow_pixel[%0d]: got %h expected %h",
                         i, {de_q[i].r, de_q[i].g, de_q[i].b}, {e, e, e});
            end
        end
    endtask

    task automatic test_truncate();
        logic [7:0] e;
        logic       hs_e;
        int         j;
        line(112, 1, 1'b0);
        open_capture();
        line(40, 2, 1'b0);
        line(40, 0, 1'b0);
        close_capture();
        collect_de();
        // 82 reads of the cut-short pass, then 2x40 of the short line
        vectors++;
        if (de_q.size() !== 162) begin
            miscompares++;
            $display("FAIL truncate_de_count: got %0d expected 162", de_q.size());
        end
        for (int i = 0; i < de_q.size() && i < 162; i++) begin
            if (i < 82) begin
                e    = exp_col(pat(1, i), 1'b0);
                hs_e = (i < 8);
            end else begin
                j    = i - 82;
                e    = exp_col(1'b1, j >= 40);
                hs_e = ((j % 40) < 8);
            end
            vectors++;
            if ({de_q[i].r, de_q[i].g, de_q[i].b} !== {e, e, e} || de_q[i].hs !== hs_e) begin
                miscompares++;
                $display("FAIL truncate_pixel[%0d]: got rgb=%h hs=%b expected rgb=%h hs=%b",
                         i, {de_q[i].r, de_q[i].g, de_q[i].b}, de_q[i].hs, {e, e, e}, hs_e);
            end
        end
        vectors++;
        if (cap_q.size() == 0 || cap_q[cap_q.size()-1].hb !== 1'b1 || cap_q[cap_q.size()-1].de !== 1'b0) begin
            miscompares++;
            $display("FAIL truncate_wait_blank: got size=%0d expected hblank=1 de=0 at end", cap_q.size());
        end
    endtask

    task automatic test_vsync();
        int bad;
        line(112, 1, 1'b0);
        open_capture();
        line(112, 0, 1'b1);
        close_capture();
        collect_de();
        bad = 0;
        foreach (de_q[i])
            if (de_q[i].vs !== 1'b1) bad++;
        vectors++;
        if (de_q.size() !== 224 || bad !== 0) begin
            miscompares++;
            $display("FAIL vsync_high: got de=%0d vs_low=%0d expected de=224 vs_low=0", de_q.size(), bad);
        end
        pix(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        vectors++;
        if (vs_out !== 1'b0) begin
            miscompares++;
            $display("FAIL vsync_clear: got %b expected 0", vs_out);
        end
    endtask

    task automatic test_reset_midline();
        line(112, 1, 1'b0);
        pix(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) pix(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (de_out !== 1'b1) begin
            miscompares++;
            $display("FAIL midline_active: got de=%b expected 1", de_out);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({r, g, b, hs_out, vs_out, hblank_out, vblank_out, de_out, overflow} !== 30'h0) begin
            miscompares++;
            $display("FAIL midline_reset: got %h expected 0",
                     {r, g, b, hs_out, vs_out, hblank_out, vblank_out, de_out, overflow});
        end
        pix(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        open_capture();
        for (int i = 0; i < 50; i++) pix(pat(1, i), 1'b0, 1'b0, 1'b0, 1'b0);
        line(112, 1, 1'b0);
        cap_en = 1'b0;
        collect_de();
        vectors++;
        if (de_q.size() !== 0) begin
            miscompares++;
            $display("FAIL reset_first_edge_quiet: got %0d active samples expected 0", de_q.size());
        end
        open_capture();
        line(112, 0, 1'b0);
        close_capture();
        collect_de();
        vectors++;
        if (de_q.size() !== 224) begin
            miscompares++;
            $display("FAIL reset_second_edge_replay: got %0d expected 224", de_q.size());
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_pattern();
        test_overflow();
        test_truncate();
        test_vsync();
        test_reset_midline();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
